// File: rtl/peridot_swi_flashread_if.sv
// Avalon-MM slave bus and interrupt line of the flash read sequencer.
interface peridot_swi_flashread_if;
  logic [1:0]  avs_address;
  logic        avs_read;
  logic [31:0] avs_readdata;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic        ins_irq;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata, ins_irq
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata, ins_irq
  );
endinterface

// File: rtl/peridot_swi_flashread.sv
// Autonomous SPI-flash READ sequencer with a byte receive FIFO popped over Avalon-MM.
// Define PERIDOT_SWI_FLASHREAD_FASTREAD_EN to use FAST_READ (0x0B) with 8 dummy clocks.
module peridot_swi_flashread #(
  parameter int CLOCKFREQ        = 25000000,
  parameter int SPIFLASH_MAXFREQ = 20000000,
  parameter int FIFO_DEPTH_LOG2  = 4
) (
  input  logic                          csi_clk,
  input  logic                          rsi_reset,
  peridot_swi_flashread_if.slave        avs,
  output logic                          coe_cso_n,
  output logic                          coe_dclk,
  output logic                          coe_asdo,
  input  logic                          coe_data0
);

  localparam int CLKDIV_RAW = (CLOCKFREQ + 2 * SPIFLASH_MAXFREQ - 1) / (2 * SPIFLASH_MAXFREQ) - 1;
  localparam int CLKDIV     = (CLKDIV_RAW < 0) ? 0 : CLKDIV_RAW;
  localparam int DIV_W      = (CLKDIV < 1) ? 1 : $clog2(CLKDIV + 1);
  localparam int DEPTH      = 1 << FIFO_DEPTH_LOG2;

  localparam logic [DIV_W-1:0]         DIV_LAST  = DIV_W'(CLKDIV);
  localparam logic [FIFO_DEPTH_LOG2:0] FIFO_FULL = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);

`ifdef PERIDOT_SWI_FLASHREAD_FASTREAD_EN
  localparam logic [7:0] CMD_BYTE = 8'h0B;
`else
  localparam logic [7:0] CMD_BYTE = 8'h03;
`endif

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CMD   = 3'd1;
  localparam logic [2:0] ST_ADDR  = 3'd2;
  localparam logic [2:0] ST_DATA  = 3'd4;
  localparam logic [2:0] ST_HOLD  = 3'd5;
  localparam logic [2:0] ST_END   = 3'd6;
`ifdef PERIDOT_SWI_FLASHREAD_FASTREAD_EN
  localparam logic [2:0] ST_DUMMY = 3'd3;
`endif

  logic [2:0]       state;
  logic [DIV_W-1:0] div_cnt;
  logic             phase;
  logic [4:0]       bit_cnt;
  logic [31:0]      tx_sr;
  logic [7:0]       rx_sr;
  logic [15:0]      remaining;

  logic [23:0] addr;
  logic [15:0] length;
  logic        irqena;
  logic        done;
  logic        aborted;

  logic [7:0]                 fifo_mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
  logic [FIFO_DEPTH_LOG2:0]   fifo_count;

  logic busy;
  logic wr0;
  logic wr1;
  logic wr2;
  logic do_abort;
  logic do_start;
  logic do_pop;
  logic fifo_valid;
  logic tick;
  logic is_dummy;
  logic shifting;
  logic rise_now;
  logic push;
  logic [7:0] push_data;
  logic unused_wdata;

  assign busy       = (state != ST_IDLE);
  assign wr0        = avs.avs_write && (avs.avs_address == 2'd0);
  assign wr1        = avs.avs_write && (avs.avs_address == 2'd1);
  assign wr2        = avs.avs_write && (avs.avs_address == 2'd2);
  // Abort takes precedence over a start written in the same word.
  assign do_abort   = wr2 && avs.avs_writedata[1] && busy;
  assign do_start   = wr2 && avs.avs_writedata[0] && !avs.avs_writedata[1] && !busy;
  assign fifo_valid = (fifo_count != '0);
  assign do_pop     = avs.avs_read && (avs.avs_address == 2'd3) && fifo_valid;
  assign unused_wdata = ^avs.avs_writedata[31:24];

`ifdef PERIDOT_SWI_FLASHREAD_FASTREAD_EN
  assign is_dummy = (state == ST_DUMMY);
`else
  assign is_dummy = 1'b0;
`endif

  assign tick      = (div_cnt == DIV_LAST);
  assign shifting  = (state == ST_CMD) || (state == ST_ADDR) || (state == ST_DATA) || is_dummy;
  assign rise_now  = shifting && tick && !phase;
  assign push      = rise_now && (state == ST_DATA) && (bit_cnt == 5'd7);
  assign push_data = {rx_sr[6:0], coe_data0};

  assign avs.ins_irq = irqena & done;

  always_comb begin
    avs.avs_readdata = 32'h0;
    case (avs.avs_address)
      2'd0: avs.avs_readdata = {8'h0, addr};
      2'd1: avs.avs_readdata = {16'h0, length};
      2'd2: avs.avs_readdata = {16'h0, irqena, 4'h0, aborted, done, 8'h0, busy};
      default: avs.avs_readdata = fifo_valid ? {23'h0, 1'b1, fifo_mem[rd_ptr]} : 32'h0;
    endcase
  end

  always_ff @(posedge csi_clk) begin
    if (push) fifo_mem[wr_ptr] <= push_data;
  end

  // A new start flushes whatever the previous transfer left behind.
  always_ff @(posedge csi_clk or posedge rsi_reset) begin
    if (rsi_reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (do_start) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, do_pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge csi_clk or posedge rsi_reset) begin
    if (rsi_reset) begin
      state     <= ST_IDLE;
      div_cnt   <= '0;
      phase     <= 1'b0;
      bit_cnt   <= '0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      remaining <= '0;
      addr      <= '0;
      length    <= '0;
      irqena    <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
      coe_cso_n <= 1'b1;
      coe_dclk  <= 1'b0;
      coe_asdo  <= 1'b0;
    end else begin
      if (wr2) irqena <= avs.avs_writedata[15];
      if (wr2 && avs.avs_writedata[9]) done <= 1'b0;
      if (!busy && wr0) addr   <= avs.avs_writedata[23:0];
      if (!busy && wr1) length <= avs.avs_writedata[15:0];

      if (do_abort) begin
        state     <= ST_END;
        div_cnt   <= '0;
        phase     <= 1'b0;
        aborted   <= 1'b1;
        coe_cso_n <= 1'b1;
        coe_dclk  <= 1'b0;
        coe_asdo  <= 1'b0;
      end else if (do_start) begin
        aborted <= 1'b0;
        if (length == 16'h0) begin
          done <= 1'b1;
        end else begin
          done      <= 1'b0;
          state     <= ST_CMD;
          div_cnt   <= '0;
          phase     <= 1'b0;
          bit_cnt   <= '0;
          tx_sr     <= {CMD_BYTE, addr};
          remaining <= length;
          coe_cso_n <= 1'b0;
          coe_dclk  <= 1'b0;
          coe_asdo  <= CMD_BYTE[7];
        end
      end else if (shifting) begin
        if (!tick) begin
          div_cnt <= div_cnt + 1'b1;
        end else if (!phase) begin
          // Rising SCLK at mid-bit: sample MISO, complete a byte on its 8th bit.
          div_cnt  <= '0;
          phase    <= 1'b1;
          coe_dclk <= 1'b1;
          rx_sr    <= push_data;
          if (push) remaining <= remaining - 1'b1;
        end else begin
          div_cnt  <= '0;
          phase    <= 1'b0;
          coe_dclk <= 1'b0;
          bit_cnt  <= bit_cnt + 1'b1;
          tx_sr    <= {tx_sr[30:0], 1'b0};
          coe_asdo <= tx_sr[30];
          case (state)
            ST_CMD: begin
              if (bit_cnt == 5'd7) begin
                state   <= ST_ADDR;
                bit_cnt <= '0;
              end
            end
            ST_ADDR: begin
              if (bit_cnt == 5'd23) begin
                bit_cnt  <= '0;
                coe_asdo <= 1'b0;
`ifdef PERIDOT_SWI_FLASHREAD_FASTREAD_EN
                state    <= ST_DUMMY;
`else
                state    <= ST_DATA;
`endif
              end
            end
`ifdef PERIDOT_SWI_FLASHREAD_FASTREAD_EN
            ST_DUMMY: begin
              coe_asdo <= 1'b0;
              if (bit_cnt == 5'd7) begin
                bit_cnt <= '0;
                state   <= ST_DATA;
              end
            end
`endif
            default: begin
              coe_asdo <= 1'b0;
              if (bit_cnt == 5'd7) begin
                bit_cnt <= '0;
                if (remaining == 16'h0) begin
                  state     <= ST_END;
                  coe_cso_n <= 1'b1;
                end else if (fifo_count == FIFO_FULL) begin
                  state <= ST_HOLD;
                end
              end
            end
          endcase
        end
      end else begin
        case (state)
          ST_HOLD: begin
            if (fifo_count != FIFO_FULL) begin
              state   <= ST_DATA;
              div_cnt <= '0;
              phase   <= 1'b0;
              bit_cnt <= '0;
            end
          end
          // CS stays high with SCLK low for one half-period before going idle.
          ST_END: begin
            if (tick) begin
              state   <= ST_IDLE;
              div_cnt <= '0;
              done    <= 1'b1;
            end else begin
              div_cnt <= div_cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_peridot_swi_flashread.sv
// Self-checking bench for peridot_swi_flashread with a behavioural SPI flash model.
module tb_peridot_swi_flashread;

`ifdef PERIDOT_SWI_FLASHREAD_FASTREAD_EN
  localparam logic [7:0] EXP_CMD    = 8'h0B;
  localparam int         DUMMY_BITS = 8;
`else
  localparam logic [7:0] EXP_CMD    = 8'h03;
  localparam int         DUMMY_BITS = 0;
`endif
  localparam int DATA_START = 32 + DUMMY_BITS;
  localparam int CLK_PERIOD = 10;

  logic csi_clk   = 1'b0;
  logic rsi_reset = 1'b1;
  logic coe_cso_n;
  logic coe_dclk;
  logic coe_asdo;
  logic coe_data0 = 1'b0;

  peridot_swi_flashread_if bus ();

  peridot_swi_flashread dut (
    .csi_clk   (csi_clk),
    .rsi_reset (rsi_reset),
    .avs       (bus),
    .coe_cso_n (coe_cso_n),
    .coe_dclk  (coe_dclk),
    .coe_asdo  (coe_asdo),
    .coe_data0 (coe_data0)
  );

  always #(CLK_PERIOD / 2) csi_clk = ~csi_clk;

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Flash contents: every address holds its low byte plus 0x4A (0x123456 -> 0xA0).
  function automatic logic [7:0] flashByte(input logic [23:0] a);
    return a[7:0] + 8'h4A;
  endfunction

  int          n_bits   = 0;
  int          pulses   = 0;
  int          cs_falls = 0;
  logic [31:0] cap      = '0;
  bit          mosi_bad = 1'b0;
  time         last_rise = 0;
  time         min_gap  = '1;
  time         max_gap  = 0;
  int          drv_idx;
  logic [7:0]  drv_byte;

  always @(negedge coe_cso_n) begin
    n_bits   = 0;
    cap      = '0;
    mosi_bad = 1'b0;
    min_gap  = '1;
    max_gap  = 0;
    cs_falls++;
  end

  always @(posedge coe_dclk) begin
    pulses++;
    if (!coe_cso_n) begin
      if (n_bits < 32) cap = {cap[30:0], coe_asdo};
      else if (coe_asdo) mosi_bad = 1'b1;
      if (n_bits > 0) begin
        if ($time - last_rise < min_gap) min_gap = $time - last_rise;
        if ($time - last_rise > max_gap) max_gap = $time - last_rise;
      end
      last_rise = $time;
      n_bits++;
    end
  end

  always @(negedge coe_dclk) begin
    if (!coe_cso_n && n_bits >= DATA_START) begin
      drv_idx   = n_bits - DATA_START;
      drv_byte  = flashByte(cap[23:0] + 24'(drv_idx / 8));
      coe_data0 = drv_byte[7 - (drv_idx % 8)];
    end
  end

  task automatic avWrite(input logic [1:0] a, input logic [31:0] d);
    @(negedge csi_clk);
    bus.avs_address   = a;
    bus.avs_writedata = d;
    bus.avs_write     = 1'b1;
    @(negedge csi_clk);
    bus.avs_write     = 1'b0;
  endtask

  task automatic avRead(input logic [1:0] a, output logic [31:0] d);
    @(negedge csi_clk);
    bus.avs_address = a;
    bus.avs_read    = 1'b1;
    #1 d = bus.avs_readdata;
    @(negedge csi_clk);
    bus.avs_read    = 1'b0;
  endtask

  task automatic waitIdle(input string tag, input int max_reads);
    logic [31:0] r;
    int i;
    for (i = 0; i < max_reads; i++) begin
      avRead(2'd2, r);
      if (!r[0]) break;
    end
    checkOutput({tag, " reached idle"}, 32'(i < max_reads), 32'd1);
  endtask

  // Runs a transfer while draining the FIFO and checks every byte against the flash model.
  task automatic applyStimulus(input logic [23:0] a, input int len, input string tag);
    logic [31:0] st;
    logic [31:0] r;
    int got;
    bit finished;
    got      = 0;
    finished = 1'b0;
    pulses   = 0;
    avWrite(2'd0, {8'h0, a});
    avWrite(2'd1, 32'(len));
    avWrite(2'd2, 32'h0000_0001);
    for (int it = 0; it < 3000 && !finished; it++) begin
      avRead(2'd2, st);
      do begin
        avRead(2'd3, r);
        if (r[8]) begin
          checkOutput($sformatf("%s byte%0d", tag, got), r, {23'h0, 1'b1, flashByte(a + 24'(got))});
          got++;
        end
      end while (r[8]);
      if (!st[0]) finished = 1'b1;
    end
    checkOutput({tag, " finished"}, 32'(finished), 32'd1);
    checkOutput({tag, " byte count"}, 32'(got), 32'(len));
    checkOutput({tag, " status"}, st, 32'h0000_0200);
    checkOutput({tag, " sclk pulses"}, 32'(pulses), 32'(DATA_START + 8 * len));
    checkOutput({tag, " command"}, {24'h0, cap[31:24]}, {24'h0, EXP_CMD});
    checkOutput({tag, " address"}, {8'h0, cap[23:0]}, {8'h0, a});
    checkOutput({tag, " mosi low after addr"}, 32'(mosi_bad), 32'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d checks so far", tests_run);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] r;
    logic [23:0] a;
    int falls0;
    int len;
    bit timed_out;

    bus.avs_address   = 2'd0;
    bus.avs_read      = 1'b0;
    bus.avs_write     = 1'b0;
    bus.avs_writedata = 32'h0;

    // Reset state
    repeat (3) @(negedge csi_clk);
    rsi_reset = 1'b0;
    checkOutput("reset cso_n", {31'h0, coe_cso_n}, 32'd1);
    checkOutput("reset dclk", {31'h0, coe_dclk}, 32'd0);
    checkOutput("reset asdo", {31'h0, coe_asdo}, 32'd0);
    checkOutput("reset irq", {31'h0, bus.ins_irq}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      avRead(2'(i), r);
      checkOutput($sformatf("reset reg%0d", i), r, 32'h0);
    end

    // Basic 4-byte read with irq enabled
    pulses = 0;
    avWrite(2'd0, 32'h0012_3456);
    avWrite(2'd1, 32'd4);
    avRead(2'd0, r);
    checkOutput("reg0 readback", r, 32'h0012_3456);
    avRead(2'd1, r);
    checkOutput("reg1 readback", r, 32'd4);
    avWrite(2'd2, 32'h0000_8001);
    waitIdle("basic", 500);
    checkOutput("basic command", {24'h0, cap[31:24]}, {24'h0, EXP_CMD});
    checkOutput("basic address", {8'h0, cap[23:0]}, 32'h0012_3456);
    checkOutput("basic pulses", 32'(pulses), 32'(DATA_START + 32));
    checkOutput("basic min bit period", 32'(min_gap), 32'(2 * CLK_PERIOD));
    checkOutput("basic max bit period", 32'(max_gap), 32'(2 * CLK_PERIOD));
    checkOutput("basic cso_n after", {31'h0, coe_cso_n}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      avRead(2'd3, r);
      checkOutput($sformatf("basic rx%0d", i), r, 32'h1A0 + 32'(i));
    end
    avRead(2'd3, r);
    checkOutput("basic rx empty", r, 32'h0);
    avRead(2'd2, r);
    checkOutput("basic status", r, 32'h0000_8200);
    checkOutput("basic irq", {31'h0, bus.ins_irq}, 32'd1);
    avWrite(2'd2, 32'h0000_0200);
    checkOutput("done clear irq", {31'h0, bus.ins_irq}, 32'd0);
    avRead(2'd2, r);
    checkOutput("done clear status", r, 32'h0);

    // Zero length: done immediately, flash untouched
    pulses = 0;
    falls0 = cs_falls;
    avWrite(2'd1, 32'd0);
    avWrite(2'd2, 32'h0000_8001);
    checkOutput("len0 done next cycle", {31'h0, bus.ins_irq}, 32'd1);
    repeat (10) @(negedge csi_clk);
    checkOutput("len0 cs never low", 32'(cs_falls - falls0), 32'd0);
    checkOutput("len0 pulses", 32'(pulses), 32'd0);
    avRead(2'd2, r);
    checkOutput("len0 status", r, 32'h0000_8200);
    avWrite(2'd2, 32'h0000_0200);

    // FIFO full: 20 bytes, no pops until HOLD is reached
    a = 24'($urandom) | 24'h1;
    pulses = 0;
    avWrite(2'd0, {8'h0, a});
    avWrite(2'd1, 32'd20);
    avWrite(2'd2, 32'h0000_0001);
    timed_out = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge csi_clk);
      if (pulses >= DATA_START + 128) begin
        timed_out = 1'b0;
        break;
      end
    end
    checkOutput("hold reached", 32'(timed_out), 32'd0);
    repeat (40) @(negedge csi_clk);
    checkOutput("hold cso_n", {31'h0, coe_cso_n}, 32'd0);
    checkOutput("hold dclk", {31'h0, coe_dclk}, 32'd0);
    checkOutput("hold pulses", 32'(pulses), 32'(DATA_START + 128));
    avWrite(2'd0, 32'h00AB_CDEF);
    avRead(2'd0, r);
    checkOutput("addr write ignored busy", r, {8'h0, a});
    avRead(2'd2, r);
    checkOutput("hold busy", r, 32'h1);
    for (int k = 0; k < 4; k++) begin
      avRead(2'd3, r);
      checkOutput($sformatf("hold pop%0d", k), r, {23'h0, 1'b1, flashByte(a + 24'(k))});
    end
    waitIdle("hold resume", 500);
    checkOutput("hold total pulses", 32'(pulses), 32'(DATA_START + 160));
    for (int k = 4; k < 20; k++) begin
      avRead(2'd3, r);
      checkOutput($sformatf("hold pop%0d", k), r, {23'h0, 1'b1, flashByte(a + 24'(k))});
    end
    avRead(2'd3, r);
    checkOutput("hold fifo empty", r, 32'h0);

    // Abort during the address phase
    a = 24'($urandom);
    avWrite(2'd0, {8'h0, a});
    avWrite(2'd1, 32'd8);
    avWrite(2'd2, 32'h0000_0001);
    timed_out = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge csi_clk);
      if (!coe_cso_n && n_bits >= 12) begin
        timed_out = 1'b0;
        break;
      end
    end
    checkOutput("abort reached addr", 32'(timed_out), 32'd0);
    avWrite(2'd2, 32'h0000_0003);
    checkOutput("abort cso_n", {31'h0, coe_cso_n}, 32'd1);
    checkOutput("abort dclk", {31'h0, coe_dclk}, 32'd0);
    waitIdle("abort", 50);
    avRead(2'd2, r);
    checkOutput("abort status", r, 32'h0000_0600);
    avRead(2'd3, r);
    checkOutput("abort fifo empty", r, 32'h0);
    applyStimulus(24'($urandom), 2, "after abort");

    // Asynchronous reset in the middle of a data byte
    a = 24'($urandom) | 24'h1;
    avWrite(2'd0, {8'h0, a});
    avWrite(2'd1, 32'd8);
    avWrite(2'd2, 32'h0000_8001);
    timed_out = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge csi_clk);
      if (!coe_cso_n && coe_dclk && n_bits >= DATA_START + 10) begin
        timed_out = 1'b0;
        break;
      end
    end
    checkOutput("reset reached data", 32'(timed_out), 32'd0);
    #2 rsi_reset = 1'b1;
    #1;
    checkOutput("async reset cso_n", {31'h0, coe_cso_n}, 32'd1);
    checkOutput("async reset dclk", {31'h0, coe_dclk}, 32'd0);
    checkOutput("async reset asdo", {31'h0, coe_asdo}, 32'd0);
    checkOutput("async reset irq", {31'h0, bus.ins_irq}, 32'd0);
    @(negedge csi_clk);
    rsi_reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      avRead(2'(i), r);
      checkOutput($sformatf("post reset reg%0d", i), r, 32'h0);
    end

    // FAST_READ example transfer (plain READ timing when the feature is off)
    applyStimulus(24'h000010, 1, "short");

    // Randomised transfers, some long enough to stall on a full FIFO
    for (int t = 0; t < 4; t++) begin
      len = int'($urandom_range(1, 40));
      applyStimulus(24'($urandom), len, $sformatf("random%0d", t));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
